// File: rtl/reg_context_engine.sv
// ---------------------------------------------------------------------------
// reg_context_engine
//
// Bulk save/restore of the general purpose register file on kernel entry/exit
// and on interrupts. SAVE walks $1..$(regCount-1) through the register-file
// read port and streams each word out on a valid/ready port. RESTORE takes a
// valid/ready stream and writes each beat back through the register-file
// write port. $0 is never touched. The core is stalled while busy.
//
// Ports
//   clk            clock
//   nReset         asynchronous active-low reset
//   saveReq        start SAVE (sampled only in IDLE, wins over restoreReq)
//   restoreReq     start RESTORE (sampled only in IDLE)
//   abort          synchronous abort of the current operation
//   busy / stall   high whenever the engine is not IDLE
//   done           one-cycle pulse on normal completion
//   rfRAddress     register-file read address
//   rfRData        register-file read data (combinational from rfRAddress)
//   rfWriteEnable  register-file write enable
//   rfWAddress     register-file write address
//   rfWData        register-file write data
//   outValid/outData/outReady   save stream (engine is the source)
//   inValid/inData/inReady      restore stream (engine is the sink)
// ---------------------------------------------------------------------------
module reg_context_engine #(
   parameter int size     = 32,
   parameter int regCount = 32,
   parameter int length   = $clog2(regCount)
) (
   input  logic              clk,
   input  logic              nReset,
   input  logic              saveReq,
   input  logic              restoreReq,
   input  logic              abort,
   output logic              busy,
   output logic              stall,
   output logic              done,
   output logic [length-1:0] rfRAddress,
   input  logic [size-1:0]   rfRData,
   output logic              rfWriteEnable,
   output logic [length-1:0] rfWAddress,
   output logic [size-1:0]   rfWData,
   output logic              outValid,
   output logic [size-1:0]   outData,
   input  logic              outReady,
   input  logic              inValid,
   input  logic [size-1:0]   inData,
   output logic              inReady
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAVE    = 2'd1,
      RESTORE = 2'd2,
      DONE    = 2'd3
   } stateT;

   localparam logic [length-1:0] firstIdx = length'(1);
   localparam logic [length-1:0] lastIdx  = length'(regCount - 1);

   stateT             state;
   stateT             nextState;
   logic [length-1:0] idx;
   logic [length-1:0] nextIdx;
   logic              beat;

   // A beat fires when the active stream handshakes: in SAVE the engine
   // always offers data, in RESTORE it always accepts, so only the partner's
   // signal decides.
   assign beat = ((state == SAVE) && outReady) || ((state == RESTORE) && inValid);

   // State and register index. idx restarts at $1 whenever an operation
   // begins, finishes or is abandoned, so it never wraps onto $0.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
         idx   <= firstIdx;
      end else begin
         state <= nextState;
         idx   <= nextIdx;
      end
   end

   // Next-state logic. The last beat at index regCount-1 moves to DONE.
   // abort overrides everything but does not cancel the outputs of the
   // current cycle, so a beat that handshakes alongside abort still lands.
   always_comb begin
      nextState = state;
      nextIdx   = idx;
      case (state)
         IDLE: begin
            nextIdx = firstIdx;
            if (saveReq) begin
               nextState = SAVE;
            end else if (restoreReq) begin
               nextState = RESTORE;
            end
         end
         SAVE, RESTORE: begin
            if (beat) begin
               if (idx == lastIdx) begin
                  nextState = DONE;
                  nextIdx   = firstIdx;
               end else begin
                  nextIdx = idx + firstIdx;
               end
            end
         end
         DONE: begin
            nextState = IDLE;
            nextIdx   = firstIdx;
         end
         default: begin
            nextState = IDLE;
            nextIdx   = firstIdx;
         end
      endcase
      if (abort && (state != IDLE)) begin
         nextState = IDLE;
         nextIdx   = firstIdx;
      end
   end

   // Outputs are decoded from state alone (plus the stream inputs), so the
   // asynchronous reset forces every output to zero immediately. The write
   // port passes restore data straight through in the handshake cycle.
   always_comb begin
      busy          = (state != IDLE);
      stall         = (state != IDLE);
      done          = 1'b0;
      rfRAddress    = '0;
      rfWriteEnable = 1'b0;
      rfWAddress    = '0;
      rfWData       = '0;
      outValid      = 1'b0;
      outData       = '0;
      inReady       = 1'b0;
      case (state)
         SAVE: begin
            rfRAddress = idx;
            outValid   = 1'b1;
            outData    = rfRData;
         end
         RESTORE: begin
            inReady    = 1'b1;
            rfWAddress = idx;
            if (inValid) begin
               rfWriteEnable = 1'b1;
               rfWData       = inData;
            end
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_reg_context_engine.sv
// ---------------------------------------------------------------------------
// tb_reg_context_engine
//
// Drives reg_context_engine against a behavioural 32 x 32 register file.
// Expected save-stream words are queued when a save is launched; a monitor on
// the falling edge pops and compares them whenever a beat handshakes, and
// also watches stall/busy, write-address and hold-under-backpressure rules.
// ---------------------------------------------------------------------------
module tb_reg_context_engine;

   localparam int size     = 32;
   localparam int regCount = 32;
   localparam int length   = 5;

   logic              clk = 1'b0;
   logic              nReset;
   logic              saveReq;
   logic              restoreReq;
   logic              abort;
   logic              busy;
   logic              stall;
   logic              done;
   logic [length-1:0] rfRAddress;
   logic [size-1:0]   rfRData;
   logic              rfWriteEnable;
   logic [length-1:0] rfWAddress;
   logic [size-1:0]   rfWData;
   logic              outValid;
   logic [size-1:0]   outData;
   logic              outReady;
   logic              inValid;
   logic [size-1:0]   inData;
   logic              inReady;

   logic [31:0] regs [0:31];
   logic        preload = 1'b0;
   logic [31:0] preloadBase = 32'h0;
   int          weCount = 0;

   logic [31:0] expQ[$];
   int          beatCount = 0;
   int          doneCount = 0;
   int          checks = 0;
   int          fails = 0;

   logic        prevHold = 1'b0;
   logic [31:0] prevData = 32'h0;
   logic [4:0]  prevAddr = 5'h0;

   reg_context_engine #(.size(size), .regCount(regCount), .length(length)) dut (
      .clk(clk),
      .nReset(nReset),
      .saveReq(saveReq),
      .restoreReq(restoreReq),
      .abort(abort),
      .busy(busy),
      .stall(stall),
      .done(done),
      .rfRAddress(rfRAddress),
      .rfRData(rfRData),
      .rfWriteEnable(rfWriteEnable),
      .rfWAddress(rfWAddress),
      .rfWData(rfWData),
      .outValid(outValid),
      .outData(outData),
      .outReady(outReady),
      .inValid(inValid),
      .inData(inData),
      .inReady(inReady)
   );

   always #5 clk = ~clk;

   // Register file model: combinational read, write on the rising edge.
   // preload fills $n with base+n ($0 stays zero) and clears the write count.
   assign rfRData = regs[rfRAddress];

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= (i == 0) ? 32'h0 : preloadBase + 32'(i);
         end
         weCount <= 0;
      end else if (rfWriteEnable) begin
         regs[rfWAddress] <= rfWData;
         weCount <= weCount + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: scoreboard pop on every save handshake plus invariant checks.
   always @(negedge clk) begin
      checkOutput("stallEqBusy", 32'(stall), 32'(busy));
      if (done) doneCount++;
      if (rfWriteEnable) checkOutput("wAddrNonZero", 32'(rfWAddress == 5'd0), 32'd0);
      if (prevHold && outValid) begin
         checkOutput("holdData", outData, prevData);
         checkOutput("holdAddr", 32'(rfRAddress), 32'(prevAddr));
      end
      if (outValid && outReady) begin
         beatCount++;
         if (expQ.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpectedBeat: got 0x%0h expected no beat", outData);
         end else begin
            checkOutput("saveBeat", outData, expQ.pop_front());
         end
      end
      prevHold = outValid && !outReady;
      prevData = outData;
      prevAddr = rfRAddress;
   end

   task automatic applyStimulus(input bit save, input bit restore);
      saveReq    = save;
      restoreReq = restore;
      @(posedge clk);
      #1;
      saveReq    = 1'b0;
      restoreReq = 1'b0;
   endtask

   task automatic preloadRegs(input logic [31:0] base);
      preloadBase = base;
      preload     = 1'b1;
      @(posedge clk);
      #1;
      preload = 1'b0;
   endtask

   task automatic pushSave(input int count);
      for (int n = 1; n <= count; n++) expQ.push_back(32'h100 + 32'(n));
   endtask

   // Counts falling edges until done, checking stall on every one of them.
   task automatic waitDone(input string name, output int cycles);
      int stallLow;
      stallLow = 0;
      cycles   = 0;
      do begin
         @(negedge clk);
         cycles++;
         if (!stall) stallLow++;
      end while (!done && cycles < 300);
      checkOutput({name, "Finished"}, 32'(done), 32'd1);
      checkOutput({name, "StallHeld"}, 32'(stallLow), 32'd0);
   endtask

   task automatic checkAllZero(input string name);
      checkOutput({name, "Busy"}, 32'(busy), 32'd0);
      checkOutput({name, "Stall"}, 32'(stall), 32'd0);
      checkOutput({name, "Done"}, 32'(done), 32'd0);
      checkOutput({name, "OutValid"}, 32'(outValid), 32'd0);
      checkOutput({name, "OutData"}, outData, 32'd0);
      checkOutput({name, "InReady"}, 32'(inReady), 32'd0);
      checkOutput({name, "WriteEnable"}, 32'(rfWriteEnable), 32'd0);
      checkOutput({name, "RAddress"}, 32'(rfRAddress), 32'd0);
      checkOutput({name, "WAddress"}, 32'(rfWAddress), 32'd0);
      checkOutput({name, "WData"}, rfWData, 32'd0);
   endtask

   initial begin
      #100000;
      fails++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cycles;
      int k;
      int n;
      int doneBefore;
      int pat[4] = '{1, 0, 0, 1};
      int gap[5] = '{1, 0, 1, 1, 0};

      nReset     = 1'b0;
      saveReq    = 1'b0;
      restoreReq = 1'b0;
      abort      = 1'b0;
      outReady   = 1'b0;
      inValid    = 1'b0;
      inData     = 32'h0;
      @(posedge clk);
      #1;
      preloadRegs(32'h100);
      saveReq = 1'b1;
      @(posedge clk);
      #1;
      checkAllZero("reset");
      saveReq = 1'b0;
      nReset  = 1'b1;
      @(posedge clk);
      #1;

      // Plain save with the sink always ready.
      $display("[TB] save, outReady held high");
      outReady  = 1'b1;
      beatCount = 0;
      pushSave(31);
      doneBefore = doneCount;
      applyStimulus(1'b1, 1'b0);
      waitDone("save", cycles);
      checkOutput("saveLatency", 32'(cycles), 32'd32);
      checkOutput("saveBeats", 32'(beatCount), 32'd31);
      @(negedge clk);
      checkOutput("saveIdleAfter", 32'(busy), 32'd0);
      checkOutput("saveQueueEmpty", 32'(expQ.size()), 32'd0);
      checkOutput("saveDonePulses", 32'(doneCount - doneBefore), 32'd1);
      @(posedge clk);
      #1;

      // Save with the sink stalling in a 1,0,0,1 pattern.
      $display("[TB] save with backpressure");
      beatCount = 0;
      pushSave(31);
      outReady = 1'b0;
      applyStimulus(1'b1, 1'b0);
      k = 0;
      forever begin
         outReady = pat[k % 4][0];
         k++;
         @(negedge clk);
         if (done || k >= 400) break;
         @(posedge clk);
         #1;
      end
      checkOutput("bpFinished", 32'(done), 32'd1);
      checkOutput("bpBeats", 32'(beatCount), 32'd31);
      checkOutput("bpQueueEmpty", 32'(expQ.size()), 32'd0);
      @(posedge clk);
      #1;
      outReady = 1'b1;

      // Restore with a gapped source stream.
      $display("[TB] restore with gapped inValid");
      preloadRegs(32'h100);
      applyStimulus(1'b0, 1'b1);
      k = 0;
      n = 1;
      forever begin
         inValid = gap[k % 5][0];
         inData  = 32'hA000 + 32'(n);
         k++;
         @(negedge clk);
         if (inValid && inReady) n++;
         if (done || k >= 400) break;
         @(posedge clk);
         #1;
      end
      checkOutput("restoreFinished", 32'(done), 32'd1);
      @(posedge clk);
      #1;
      inValid = 1'b0;
      checkOutput("restoreBeats", 32'(n), 32'd32);
      checkOutput("restoreWrites", 32'(weCount), 32'd31);
      checkOutput("restoreReg0", regs[0], 32'h0);
      for (int i = 1; i < 32; i++) checkOutput("restoreReg", regs[i[4:0]], 32'hA000 + 32'(i));

      // Simultaneous requests choose SAVE; restoreReq during SAVE is dropped.
      $display("[TB] simultaneous requests and restoreReq during save");
      preloadRegs(32'h100);
      beatCount = 0;
      pushSave(31);
      applyStimulus(1'b1, 1'b1);
      @(negedge clk);
      checkOutput("bothReqSave", 32'(outValid), 32'd1);
      checkOutput("bothReqNoRestore", 32'(inReady), 32'd0);
      @(posedge clk);
      #1;
      restoreReq = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      restoreReq = 1'b0;
      waitDone("bothReq", cycles);
      checkOutput("bothReqBeats", 32'(beatCount), 32'd31);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("noLateRestore", 32'(busy), 32'd0);
      checkOutput("noLateWrites", 32'(weCount), 32'd0);

      // Abort a restore after ten beats.
      $display("[TB] abort after ten restore beats");
      preloadRegs(32'h100);
      applyStimulus(1'b0, 1'b1);
      for (int b = 1; b <= 10; b++) begin
         inValid = 1'b1;
         inData  = 32'hC000 + 32'(b);
         @(posedge clk);
         #1;
      end
      inValid    = 1'b0;
      abort      = 1'b1;
      doneBefore = doneCount;
      @(negedge clk);
      checkOutput("abortCycleBusy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      checkOutput("abortIdle", 32'(busy), 32'd0);
      checkOutput("abortNoDone", 32'(doneCount - doneBefore), 32'd0);
      checkOutput("abortWrites", 32'(weCount), 32'd10);
      for (int i = 1; i < 32; i++) begin
         if (i <= 10) checkOutput("abortRegNew", regs[i[4:0]], 32'hC000 + 32'(i));
         else checkOutput("abortRegOld", regs[i[4:0]], 32'h100 + 32'(i));
      end
      @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a save.
      $display("[TB] reset during save");
      preloadRegs(32'h100);
      beatCount = 0;
      pushSave(4);
      applyStimulus(1'b1, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("preResetAddr", 32'(rfRAddress), 32'd5);
      nReset = 1'b0;
      #1;
      checkAllZero("midReset");
      @(posedge clk);
      #1;
      nReset = 1'b1;
      checkOutput("resetBeats", 32'(beatCount), 32'd4);
      checkOutput("resetQueueEmpty", 32'(expQ.size()), 32'd0);
      beatCount = 0;
      pushSave(31);
      applyStimulus(1'b1, 1'b0);
      @(negedge clk);
      checkOutput("restartAddr", 32'(rfRAddress), 32'd1);
      waitDone("restart", cycles);
      checkOutput("restartBeats", 32'(beatCount), 32'd31);
      @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
